s_pipe_slice: RTL

Parametrised successor to the single-stage enable/reset register. It chains DEPTH skid-buffered register stages with a valid/ready handshake, so long paths can be pipelined without breaking flow control. It provides full throughput, registered ready on both sides and a synchronous flush. It sits between any two streaming blocks, typically on a datapath crossing a long route.

---
 rtl/fpgavn_stream_pkg.sv | 21 ++
 rtl/s_skid_stage.sv | 108 ++++++++++
 rtl/s_pipe_slice.sv | 82 ++++++++
 3 files changed

// File: rtl/fpgavn_stream_pkg.sv
// fpgavn_stream_pkg: stage state encoding and width helper shared by the streaming slices.
package fpgavn_stream_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } stage_state_e;

  function automatic int CLOG2(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 30; i++) begin
      if ((32'sd1 <<< i) < value) begin
        res = i + 1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/s_skid_stage.sv
// s_skid_stage: one main+skid register stage; both handshake outputs come straight from flops.
module s_skid_stage
  import fpgavn_stream_pkg::*;
#(
  parameter int              SIZE    = 8,
  parameter logic [SIZE-1:0] RST_VAL = {SIZE{1'b0}}
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_vld,
  output logic            in_rdy,
  input  logic [SIZE-1:0] in_dat,
  output logic            out_vld,
  input  logic            out_rdy,
  output logic [SIZE-1:0] out_dat
);

  stage_state_e    r_state;
  stage_state_e    w_state_nxt;
  logic [SIZE-1:0] r_main;
  logic [SIZE-1:0] r_skid;
  logic [SIZE-1:0] w_main_nxt;
  logic [SIZE-1:0] w_skid_nxt;
  logic            r_vld;
  logic            r_rdy;
  logic            w_vld_nxt;
  logic            w_rdy_nxt;
  logic            w_in;
  logic            w_out;

  assign w_in    = in_vld && r_rdy;
  assign w_out   = r_vld && out_rdy;
  assign in_rdy  = r_rdy;
  assign out_vld = r_vld;
  assign out_dat = r_main;

  // State and data registers; flush empties the stage but leaves data contents untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= EMPTY;
      r_main  <= RST_VAL;
      r_skid  <= RST_VAL;
      r_vld   <= 1'b0;
      r_rdy   <= 1'b0;
    end else if (flush) begin
      r_state <= EMPTY;
      r_vld   <= 1'b0;
      r_rdy   <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_main  <= w_main_nxt;
      r_skid  <= w_skid_nxt;
      r_vld   <= w_vld_nxt;
      r_rdy   <= w_rdy_nxt;
    end
  end

  // Next-state and data steering.
  always_comb begin
    w_state_nxt = r_state;
    w_main_nxt  = r_main;
    w_skid_nxt  = r_skid;
    case (r_state)
      EMPTY: begin
        if (w_in) begin
          w_state_nxt = HALF;
          w_main_nxt  = in_dat;
        end else begin
          w_state_nxt = EMPTY;
        end
      end
      HALF: begin
        case ({w_in, w_out})
          2'b11:   w_main_nxt = in_dat;
          2'b10: begin
            w_state_nxt = FULL;
            w_skid_nxt  = in_dat;
          end
          2'b01:   w_state_nxt = EMPTY;
          default: w_state_nxt = HALF;
        endcase
      end
      FULL: begin
        if (w_out) begin
          w_state_nxt = HALF;
          w_main_nxt  = r_skid;
        end else begin
          w_state_nxt = FULL;
        end
      end
      default: w_state_nxt = EMPTY;
    endcase
  end

  // Handshake flags decoded from the next state so they can be registered.
  always_comb begin
    w_vld_nxt = 1'b0;
    w_rdy_nxt = 1'b1;
    case (w_state_nxt)
      EMPTY:   begin w_vld_nxt = 1'b0; w_rdy_nxt = 1'b1; end
      HALF:    begin w_vld_nxt = 1'b1; w_rdy_nxt = 1'b1; end
      FULL:    begin w_vld_nxt = 1'b1; w_rdy_nxt = 1'b0; end
      default: begin w_vld_nxt = 1'b0; w_rdy_nxt = 1'b1; end
    endcase
  end

endmodule

// File: rtl/s_pipe_slice.sv
// s_pipe_slice: DEPTH chained skid stages with full-throughput valid/ready flow control.
// Define S_PIPE_SLICE_OCC_EN to add the registered occupancy output occ.
module s_pipe_slice
  import fpgavn_stream_pkg::*;
#(
  parameter int              SIZE    = 8,
  parameter int              DEPTH   = 2,
  parameter logic [SIZE-1:0] RST_VAL = {SIZE{1'b0}}
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            ivld,
  output logic            irdy,
  input  logic [SIZE-1:0] idat,
  output logic            ovld,
  input  logic            ordy,
  output logic [SIZE-1:0] odat
`ifdef S_PIPE_SLICE_OCC_EN
  ,
  output logic [CLOG2(2*DEPTH+1)-1:0] occ
`endif
);

  logic            w_vld [DEPTH+1];
  logic            w_rdy [DEPTH+1];
  logic [SIZE-1:0] w_dat [DEPTH+1];

  if (DEPTH < 1) begin : g_depth_check
    $error("s_pipe_slice: DEPTH must be at least 1");
  end

  assign w_vld[0]     = ivld;
  assign w_dat[0]     = idat;
  assign irdy         = w_rdy[0];
  assign ovld         = w_vld[DEPTH];
  assign odat         = w_dat[DEPTH];
  assign w_rdy[DEPTH] = ordy;

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    s_skid_stage #(
      .SIZE    (SIZE),
      .RST_VAL (RST_VAL)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .flush   (flush),
      .in_vld  (w_vld[g]),
      .in_rdy  (w_rdy[g]),
      .in_dat  (w_dat[g]),
      .out_vld (w_vld[g+1]),
      .out_rdy (w_rdy[g+1]),
      .out_dat (w_dat[g+1])
    );
  end

`ifdef S_PIPE_SLICE_OCC_EN
  localparam int OCC_W = CLOG2(2*DEPTH+1);

  logic [OCC_W-1:0] r_occ;
  logic             w_up;
  logic             w_dn;

  assign w_up = ivld && irdy;
  assign w_dn = ovld && ordy;
  assign occ  = r_occ;

  // Word count; simultaneous push and pop leave it unchanged.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_occ <= {OCC_W{1'b0}};
    end else if (w_up && !w_dn) begin
      r_occ <= r_occ + OCC_W'(1);
    end else if (w_dn && !w_up) begin
      r_occ <= r_occ - OCC_W'(1);
    end else begin
      r_occ <= r_occ;
    end
  end
`endif

endmodule
